// File: rtl/point_plotter.sv
// -----------------------------------------------------------------------------
// point_plotter
//
// Consumer end of a generated point stream (circle/line rasterisers and the
// like). Each (x, y) pair qualified by _valid is clipped against a
// FRAME_W x FRAME_H frame. In-frame points are turned into a linear
// framebuffer address (y*FRAME_W + x) and queued in a small FIFO. The FIFO
// drains through a ready/valid memory write port that always writes
// PIXEL_VALUE. The producer cannot be stalled, so a full FIFO loses points
// and raises a sticky overflow flag instead of applying backpressure.
//
// Ports
//   _clock         in   rising-edge clock
//   _reset_n       in   asynchronous active-low reset
//   _start         in   synchronous frame start: flush FIFO, clear stats/flags
//   _in0 / _in1    in   point x / y, signed 32-bit two's complement
//   _valid         in   point qualifier, one point per high cycle
//   _done          in   producer end-of-stream (level or pulse)
//   mem_addr       out  write address (held until accepted)
//   mem_data       out  write data (held until accepted)
//   mem_we         out  write request
//   mem_ready      in   memory accepts the write when mem_we && mem_ready
//   _busy          out  high while a frame is running or draining
//   frame_done     out  one-cycle pulse once the stream ended and all writes
//                       have been accepted
//   plotted_count  out  writes accepted by memory (saturating)
//   clipped_count  out  points dropped as out-of-frame (saturating)
//   overflow       out  sticky: an in-frame point was lost to a full FIFO
// -----------------------------------------------------------------------------
module point_plotter #(
  parameter int FRAME_W     = 64,
  parameter int FRAME_H     = 64,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int PIXEL_VALUE = 1,
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 16
) (
  input  logic              _clock,
  input  logic              _reset_n,
  input  logic              _start,
  input  logic [31:0]       _in0,
  input  logic [31:0]       _in1,
  input  logic              _valid,
  input  logic              _done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              _busy,
  output logic              frame_done,
  output logic [CNT_W-1:0]  plotted_count,
  output logic [CNT_W-1:0]  clipped_count,
  output logic              overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e            state_q,       state_d;
  logic [PTR_W:0]    wr_ptr_q,      wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q,      rd_ptr_d;
  logic              mem_we_q,      mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
  logic [DATA_W-1:0] mem_data_q,    mem_data_d;
  logic [CNT_W-1:0]  plotted_q,     plotted_d;
  logic [CNT_W-1:0]  clipped_q,     clipped_d;
  logic              overflow_q,    overflow_d;
  logic              done_seen_q,   done_seen_d;
  logic              frame_done_q,  frame_done_d;

  // FIFO storage holds addresses only; the pixel value is a constant.
  logic [ADDR_W-1:0] fifo_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Point classification
  // ---------------------------------------------------------------------------
  logic signed [31:0] x_s;
  logic signed [31:0] y_s;
  logic               active;
  logic               in_frame;
  logic               pt_valid;
  logic [ADDR_W-1:0]  push_addr;

  assign x_s      = $signed(_in0);
  assign y_s      = $signed(_in1);
  assign active   = (state_q != ST_IDLE);
  assign pt_valid = active && _valid;

  // Signed compares: a negative coordinate must never look like a large
  // in-range unsigned value.
  assign in_frame = (x_s >= 0) && (x_s < FRAME_W) &&
                    (y_s >= 0) && (y_s < FRAME_H);

  // Only meaningful for in-frame points, where both operands are
  // non-negative, so the unsigned product is the intended value.
  assign push_addr = ADDR_W'(_in1 * 32'(FRAME_W) + _in0);

  // ---------------------------------------------------------------------------
  // FIFO status and handshake terms
  // ---------------------------------------------------------------------------
  logic              fifo_empty;
  logic              fifo_full;
  logic [ADDR_W-1:0] fifo_head;
  logic              accept;
  logic              pop;
  logic              push;
  logic              drop;
  logic              clip;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign fifo_head  = fifo_q[rd_ptr_q[PTR_W-1:0]];

  // The port register is free either when idle or when its current write is
  // being accepted this cycle, which gives one write per cycle back-to-back.
  assign accept = mem_we_q && mem_ready;
  assign pop    = !fifo_empty && (!mem_we_q || mem_ready);

  // A pop in the same cycle frees a slot, so a full FIFO can still take
  // a point as long as the head is leaving.
  assign push = pt_valid && in_frame && (!fifo_full || pop);
  assign drop = pt_valid && in_frame && fifo_full && !pop;
  assign clip = pt_valid && !in_frame;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    plotted_d    = plotted_q;
    clipped_d    = clipped_q;
    overflow_d   = overflow_q;
    done_seen_d  = done_seen_q;
    frame_done_d = 1'b0;

    if (_start) begin
      // Start wins over everything: any in-flight write is abandoned and
      // points presented in this cycle are ignored.
      state_d     = ST_RUN;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_data_d  = '0;
      plotted_d   = '0;
      clipped_d   = '0;
      overflow_d  = 1'b0;
      done_seen_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end

      if (pop) begin
        rd_ptr_d   = rd_ptr_q + 1'b1;
        mem_we_d   = 1'b1;
        mem_addr_d = fifo_head;
        mem_data_d = DATA_W'(PIXEL_VALUE);
      end else if (accept) begin
        mem_we_d = 1'b0;
      end

      if (accept && (plotted_q != {CNT_W{1'b1}})) begin
        plotted_d = plotted_q + 1'b1;
      end

      if (clip && (clipped_q != {CNT_W{1'b1}})) begin
        clipped_d = clipped_q + 1'b1;
      end

      if (drop) begin
        overflow_d = 1'b1;
      end

      unique case (state_q)
        ST_IDLE: begin
          // Points and end-of-stream are ignored until the next start.
        end
        ST_RUN: begin
          if (_done) begin
            done_seen_d = 1'b1;
            state_d     = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // A point arriving this cycle keeps the frame open so it is
          // written before frame_done is reported.
          if (done_seen_q && fifo_empty && !mem_we_q && !push) begin
            state_d      = ST_IDLE;
            frame_done_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      plotted_q    <= '0;
      clipped_q    <= '0;
      overflow_q   <= 1'b0;
      done_seen_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      plotted_q    <= plotted_d;
      clipped_q    <= clipped_d;
      overflow_q   <= overflow_d;
      done_seen_q  <= done_seen_d;
      frame_done_q <= frame_done_d;
    end
  end

  // FIFO storage needs no reset: entries are only read between the write and
  // read pointers, and both pointers are reset.
  always_ff @(posedge _clock) begin
    if (push && !_start) begin
      fifo_q[wr_ptr_q[PTR_W-1:0]] <= push_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_addr      = mem_addr_q;
  assign mem_data      = mem_data_q;
  assign mem_we        = mem_we_q;
  assign _busy         = (state_q != ST_IDLE);
  assign frame_done    = frame_done_q;
  assign plotted_count = plotted_q;
  assign clipped_count = clipped_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_point_plotter.sv
// -----------------------------------------------------------------------------
// tb_point_plotter
//
// Scoreboard bench for point_plotter. Expected write addresses are computed
// from the coordinates when a point is driven and queued; the write monitor
// pops and compares them on every accepted write. The monitor also checks
// that a stalled write holds its address/data and that frame_done never
// fires while expected writes are still outstanding.
// -----------------------------------------------------------------------------
module tb_point_plotter;

  localparam int FRAME_W     = 64;
  localparam int FRAME_H     = 64;
  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 8;
  localparam int PIXEL_VALUE = 1;
  localparam int DEPTH       = 4;
  localparam int CNT_W       = 16;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [31:0]       in0;
  logic [31:0]       in1;
  logic              valid;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_we;
  logic              mem_ready;
  logic              busy;
  logic              frame_done;
  logic [CNT_W-1:0]  plotted_count;
  logic [CNT_W-1:0]  clipped_count;
  logic              overflow;

  point_plotter #(
    .FRAME_W(FRAME_W), .FRAME_H(FRAME_H), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .PIXEL_VALUE(PIXEL_VALUE), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    ._clock       (clk),
    ._reset_n     (rst_n),
    ._start       (start),
    ._in0         (in0),
    ._in1         (in1),
    ._valid       (valid),
    ._done        (done),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_we       (mem_we),
    .mem_ready    (mem_ready),
    ._busy        (busy),
    .frame_done   (frame_done),
    .plotted_count(plotted_count),
    .clipped_count(clipped_count),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int fd_count = 0;

  // Expected write addresses, in order.
  logic [ADDR_W-1:0] sb[$];

  // mem_ready driver mode: 0 always ready, 1 never ready, 2 toggling.
  int   ready_mode  = 0;
  logic ready_phase = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               tag, got, got, exp, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // mem_ready driver
  // ---------------------------------------------------------------------------
  task automatic set_ready_mode(input int mode);
    ready_mode  = mode;
    ready_phase = 1'b1;
    mem_ready   = (mode != 1);
  endtask

  initial begin
    mem_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       mem_ready = 1'b1;
        1:       mem_ready = 1'b0;
        default: begin
          ready_phase = ~ready_phase;
          mem_ready   = ready_phase;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Write monitor / scoreboard
  // ---------------------------------------------------------------------------
  logic              held_valid = 1'b0;
  logic [ADDR_W-1:0] held_addr  = '0;
  logic [DATA_W-1:0] held_data  = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      held_valid = 1'b0;
    end else begin
      if (held_valid && mem_we) begin
        check_val("stall_addr_stable", 32'(mem_addr), 32'(held_addr));
        check_val("stall_data_stable", 32'(mem_data), 32'(held_data));
      end
      if (mem_we && mem_ready) begin
        check_val("write_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          automatic logic [ADDR_W-1:0] exp_addr = sb.pop_front();
          $display("write addr=%0d data=%0d (expected addr %0d)",
                   mem_addr, mem_data, exp_addr);
          check_val("write_addr", 32'(mem_addr), 32'(exp_addr));
          check_val("write_data", 32'(mem_data), 32'(PIXEL_VALUE));
        end
      end
      held_valid = mem_we && !mem_ready;
      held_addr  = mem_addr;
      held_data  = mem_data;
      if (frame_done) begin
        fd_count++;
        check_val("frame_done_sb_empty", 32'(sb.size()), 32'd0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all entered and left at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic do_start();
    start = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    start    = 1'b0;
    fd_count = 0;
  endtask

  function automatic logic point_in_frame(input int x, input int y);
    return (x >= 0) && (x < FRAME_W) && (y >= 0) && (y < FRAME_H);
  endfunction

  task automatic send_point(input int x, input int y, input logic expect_write);
    valid = 1'b1;
    in0   = 32'(x);
    in1   = 32'(y);
    if (point_in_frame(x, y) && expect_write) begin
      sb.push_back(ADDR_W'(y * FRAME_W + x));
    end
    $display("point x=%0d y=%0d", x, y);
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic send_done();
    done = 1'b1;
    @(posedge clk);
    #1;
    done = 1'b0;
  endtask

  task automatic wait_frame_done(input string tag, input int max_cycles);
    automatic bit seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    check_val(tag, 32'(seen), 32'd1);
    // Let the monitor account for the pulse, then confirm it was single.
    repeat (3) @(posedge clk);
    #1;
    check_val({tag, "_pulses"}, 32'(fd_count), 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    valid = 1'b0;
    done  = 1'b0;
    in0   = '0;
    in1   = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_val("rst_mem_addr",  32'(mem_addr),      32'd0);
    check_val("rst_mem_data",  32'(mem_data),      32'd0);
    check_val("rst_mem_we",    32'(mem_we),        32'd0);
    check_val("rst_busy",      32'(busy),          32'd0);
    check_val("rst_frame_done",32'(frame_done),    32'd0);
    check_val("rst_plotted",   32'(plotted_count), 32'd0);
    check_val("rst_clipped",   32'(clipped_count), 32'd0);
    check_val("rst_overflow",  32'(overflow),      32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycles(1);

    // Points in IDLE are ignored.
    send_point(1, 1, 1'b0);
    idle_cycles(3);
    check_val("idle_ignored_we", 32'(mem_we), 32'd0);

    // Frame 1: basic plotting including both frame corners.
    set_ready_mode(0);
    do_start();
    check_val("f1_busy", 32'(busy), 32'd1);
    send_point(3, 5, 1'b1);
    send_point(0, 0, 1'b1);
    send_point(63, 63, 1'b1);
    send_done();
    wait_frame_done("f1_frame_done", 50);
    check_val("f1_plotted", 32'(plotted_count), 32'd3);
    check_val("f1_busy_after", 32'(busy), 32'd0);

    // Frame 2: clipping on each edge.
    do_start();
    send_point(-1, 5, 1'b1);
    send_point(64, 0, 1'b1);
    send_point(5, 64, 1'b1);
    send_point(0, -1, 1'b1);
    send_point(10, 2, 1'b1);
    send_done();
    wait_frame_done("f2_frame_done", 50);
    check_val("f2_clipped", 32'(clipped_count), 32'd4);
    check_val("f2_plotted", 32'(plotted_count), 32'd1);
    check_val("f2_overflow", 32'(overflow), 32'd0);

    // Frame 3: overflow with the port stalled. One point sits on the port,
    // DEPTH points are buffered, the rest are lost.
    set_ready_mode(1);
    do_start();
    for (int i = 0; i < 8; i++) begin
      send_point(i, 1, (i < DEPTH + 1) ? 1'b1 : 1'b0);
    end
    idle_cycles(2);
    check_val("f3_overflow", 32'(overflow), 32'd1);
    check_val("f3_held_we", 32'(mem_we), 32'd1);
    check_val("f3_held_addr", 32'(mem_addr), 32'(1 * FRAME_W + 0));
    check_val("f3_plotted_stalled", 32'(plotted_count), 32'd0);
    set_ready_mode(0);
    send_done();
    wait_frame_done("f3_frame_done", 50);
    check_val("f3_plotted", 32'(plotted_count), 32'd5);
    check_val("f3_overflow_sticky", 32'(overflow), 32'd1);

    // Frame 4: toggling mem_ready during a burst.
    set_ready_mode(2);
    do_start();
    check_val("f4_overflow_cleared", 32'(overflow), 32'd0);
    send_point(20, 3, 1'b1);
    send_point(21, 3, 1'b1);
    send_point(22, 4, 1'b1);
    idle_cycles(2);
    send_point(0, 10, 1'b1);
    idle_cycles(2);
    send_point(63, 0, 1'b1);
    idle_cycles(2);
    send_point(7, 9, 1'b1);
    send_done();
    wait_frame_done("f4_frame_done", 80);
    check_val("f4_plotted", 32'(plotted_count), 32'd6);
    check_val("f4_overflow", 32'(overflow), 32'd0);
    set_ready_mode(0);

    // Frame 5: point in the same cycle as done.
    do_start();
    valid = 1'b1;
    done  = 1'b1;
    in0   = 32'd2;
    in1   = 32'd2;
    sb.push_back(ADDR_W'(2 * FRAME_W + 2));
    $display("point x=2 y=2 with done");
    @(posedge clk);
    #1;
    valid = 1'b0;
    done  = 1'b0;
    wait_frame_done("f5_frame_done", 50);
    check_val("f5_plotted", 32'(plotted_count), 32'd1);

    // Frame 6: asynchronous reset in the middle of a stalled burst.
    set_ready_mode(1);
    do_start();
    send_point(-5, 0, 1'b0);
    send_point(1, 1, 1'b0);
    send_point(2, 1, 1'b0);
    begin
      automatic bit we_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (mem_we) begin
          we_seen = 1'b1;
          break;
        end
        @(posedge clk);
        #1;
      end
      check_val("f6_we_before_reset", 32'(we_seen), 32'd1);
    end
    check_val("f6_clipped_before_reset", 32'(clipped_count), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("f6_rst_mem_we",   32'(mem_we),        32'd0);
    check_val("f6_rst_mem_addr", 32'(mem_addr),      32'd0);
    check_val("f6_rst_mem_data", 32'(mem_data),      32'd0);
    check_val("f6_rst_busy",     32'(busy),          32'd0);
    check_val("f6_rst_clipped",  32'(clipped_count), 32'd0);
    check_val("f6_rst_overflow", 32'(overflow),      32'd0);
    sb.delete();
    set_ready_mode(0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycles(1);
    do_start();
    send_point(7, 7, 1'b1);
    send_done();
    wait_frame_done("f6_frame_done", 50);
    check_val("f6_plotted", 32'(plotted_count), 32'd1);
    check_val("f6_clipped", 32'(clipped_count), 32'd0);
    check_val("f6_sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
